// File: rtl/time_package.sv
// Emulator time base shared by the timed stimulus and monitor blocks.
package time_package;

   // Emulator time: unsigned fixed point, TIME_POINT fractional bits
   localparam int TIME_FORMAT = 32;
   localparam int TIME_POINT  = 16;

   // Playback sequencer states of dac_player
   typedef enum logic [1:0] {
      IDLE,
      EMPTY,
      ARMED
   } player_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with extended pointers (MSB tells full from empty)
// and a combinational head view. Push is ignored when full, pop when empty;
// flush overrides both.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic                     full,
   output logic                     empty,
   output logic [WIDTH-1:0]         head_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count     = wr_ptr_q - rd_ptr_q;
   assign head_data = mem_q[rd_ptr_q[AW-1:0]];

   // Next pointer values; flush returns both pointers to the origin
   always_comb begin
      do_push  = push && !full && !flush;
      do_pop   = pop && !empty && !flush;
      wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
      rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end
   end

   // Pointer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Entry storage; contents are don't-care while not between the pointers
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/dac_player.sv
// Timed waveform source: buffers (timestamp, value) entries and drives sig
// with each value once emulator time reaches its timestamp.
module dac_player
   import time_package::*;
#(
   parameter int sig_bits  = 1,
   parameter int sig_point = 1,
   parameter int depth     = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [TIME_FORMAT-1:0]       time_curr,
   input  logic                         enable,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [TIME_FORMAT-1:0]       in_time,
   input  logic signed [sig_bits-1:0]   in_sig,
   output logic signed [sig_bits-1:0]   sig,
   output logic                         update,
   output logic [15:0]                  late_cnt,
   output logic                         order_err
);

   localparam int AW = $clog2(depth);

   if (depth < 2 || (depth & (depth - 1)) != 0 || sig_point < 0) begin : g_bad_param
      $error("dac_player: depth must be a power of two >= 2, sig_point >= 0");
   end

   typedef struct packed {
      logic [TIME_FORMAT-1:0]     t;
      logic signed [sig_bits-1:0] v;
   } entry_t;

   entry_t                      push_ent, head_ent;
   logic                        full, empty;
   logic [AW:0]                 count, occ_next;
   logic                        time_known, push_req, order_bad, push_ok, fire;

   player_state_t               state_q, state_d;
   logic [TIME_FORMAT-1:0]      last_time_q, last_time_d;
   logic signed [sig_bits-1:0]  sig_q, sig_d;
   logic                        update_q, update_d;
   logic [15:0]                 late_cnt_q, late_cnt_d;
   logic                        order_err_q, order_err_d;

   assign push_ent  = '{t: in_time, v: in_sig};
   assign in_ready  = !full;
   assign sig       = sig_q;
   assign update    = update_q;
   assign late_cnt  = late_cnt_q;
   assign order_err = order_err_q;

   sync_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (depth)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_ok),
      .push_data (push_ent),
      .pop       (fire),
      .flush     (flush),
      .full      (full),
      .empty     (empty),
      .head_data (head_ent),
      .count     (count)
   );

   // Ordering check, fire decision and next values of all registered state.
   // The state tracks occupancy after the coming edge so a freshly pushed
   // entry is already ARMED in the following cycle.
   always_comb begin
      time_known  = ((^time_curr) !== 1'bx);
      push_req    = in_valid && in_ready && !flush;
      order_bad   = (in_time < last_time_q);
      push_ok     = push_req && !order_bad;
      fire        = (state_q == ARMED) && enable && !empty && !flush &&
                    time_known && (time_curr >= head_ent.t);

      last_time_d = last_time_q;
      if (flush) begin
         last_time_d = '0;
      end else if (push_ok) begin
         last_time_d = in_time;
      end

      order_err_d = order_err_q | (push_req && order_bad);
      sig_d       = fire ? head_ent.v : sig_q;
      update_d    = fire;

      late_cnt_d  = late_cnt_q;
      if (fire && (time_curr > head_ent.t) && (late_cnt_q != 16'hFFFF)) begin
         late_cnt_d = late_cnt_q + 16'd1;
      end

      occ_next = count + (AW+1)'(push_ok) - (AW+1)'(fire);
      if (flush) begin
         occ_next = '0;
      end

      if (!enable) begin
         state_d = IDLE;
      end else if (occ_next != '0) begin
         state_d = ARMED;
      end else begin
         state_d = EMPTY;
      end
   end

   // Sequencer state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_time_q <= '0;
         sig_q       <= '0;
         update_q    <= 1'b0;
         late_cnt_q  <= '0;
         order_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_time_q <= last_time_d;
         sig_q       <= sig_d;
         update_q    <= update_d;
         late_cnt_q  <= late_cnt_d;
         order_err_q <= order_err_d;
      end
   end

endmodule

// File: tb/tb_dac_player.sv
// Scoreboard bench for dac_player: the driver pushes every entry the buffer
// should accept into a queue; the monitor pops one entry per update pulse and
// checks value, firing time, lateness and status outputs.
module tb_dac_player;
   import time_package::*;

   localparam int SB    = 8;
   localparam int DEPTH = 16;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [TIME_FORMAT-1:0]  time_curr;
   logic                    enable, flush, in_valid, in_ready;
   logic [TIME_FORMAT-1:0]  in_time;
   logic signed [SB-1:0]    in_sig, sig;
   logic                    update;
   logic [15:0]             late_cnt;
   logic                    order_err;

   dac_player #(
      .sig_bits  (SB),
      .sig_point (4),
      .depth     (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .time_curr (time_curr),
      .enable    (enable),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_time   (in_time),
      .in_sig    (in_sig),
      .sig       (sig),
      .update    (update),
      .late_cnt  (late_cnt),
      .order_err (order_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]          t;
      logic signed [SB-1:0] v;
   } ent_t;

   ent_t                 sb_q[$];
   ent_t                 m_e;
   int                   nvec = 0;
   int                   nfail = 0;
   logic [31:0]          m_last;
   logic                 m_oerr;
   logic [15:0]          m_late;
   logic signed [SB-1:0] m_sig;
   int                   upd_total = 0;
   int                   consec = 0;
   logic                 prev_upd = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: sample just after each rising edge
   initial begin
      m_late = '0;
      m_sig  = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            m_late = '0;
            m_sig  = '0;
         end
         if (update) begin
            upd_total++;
            consec = prev_upd ? consec + 1 : 1;
            nvec++;
            if (sb_q.size() == 0) begin
               nfail++;
               $display("FAIL update_has_entry: got update with no pending entry at %0t", $time);
            end else begin
               m_e   = sb_q.pop_front();
               m_sig = m_e.v;
               chk("fire_enable", {31'b0, enable}, 32'd1);
               nvec++;
               if (!(time_curr >= m_e.t)) begin
                  nfail++;
                  $display("FAIL fire_time: fired at time %0d, required >= %0d", time_curr, m_e.t);
               end
               if ((time_curr > m_e.t) && (m_late != 16'hFFFF)) m_late = m_late + 16'd1;
            end
         end
         prev_upd = update;
         chk("sig",       {{(32-SB){sig[SB-1]}}, sig}, {{(32-SB){m_sig[SB-1]}}, m_sig});
         chk("late_cnt",  {16'b0, late_cnt}, {16'b0, m_late});
         chk("order_err", {31'b0, order_err}, {31'b0, m_oerr});
         chk("in_ready",  {31'b0, in_ready}, {31'b0, (sb_q.size() < DEPTH)});
      end
   end

   // One driver cycle; acc reports whether the model expects the push taken
   task automatic step(input logic v, input logic [31:0] t, input logic signed [SB-1:0] s,
                       input logic en, input logic fl, input logic [31:0] tc, output logic acc);
      @(negedge clk);
      in_valid  = v;
      in_time   = t;
      in_sig    = s;
      enable    = en;
      flush     = fl;
      time_curr = tc;
      acc       = 1'b0;
      if (fl) begin
         sb_q.delete();
         m_last = '0;
      end else if (v && (sb_q.size() < DEPTH)) begin
         if (t >= m_last) begin
            acc = 1'b1;
            sb_q.push_back('{t: t, v: s});
            m_last = t;
         end else begin
            m_oerr = 1'b1;
         end
      end
   endtask

   task automatic idle(input int n, input logic en, input logic [31:0] tc);
      logic a;
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, en, 1'b0, tc, a);
   endtask

   initial begin
      logic        a, got;
      int          base;
      logic [31:0] tc, t;

      rst_n = 1'b0; time_curr = '0; enable = 1'b0; flush = 1'b0;
      in_valid = 1'b0; in_time = '0; in_sig = '0;
      m_last = '0; m_oerr = 1'b0;
      #2;
      chk("rst_sig",       {{(32-SB){sig[SB-1]}}, sig}, 32'd0);
      chk("rst_update",    {31'b0, update}, 32'd0);
      chk("rst_late",      {16'b0, late_cnt}, 32'd0);
      chk("rst_order_err", {31'b0, order_err}, 32'd0);
      chk("rst_in_ready",  {31'b0, in_ready}, 32'd1);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // Basic playback with a ramping clock
      step(1'b1, 32'd10, 8'sd5, 1'b0, 1'b0, 32'd0, a);
      step(1'b1, 32'd20, -8'sd3, 1'b0, 1'b0, 32'd0, a);
      base = upd_total;
      for (int i = 0; i <= 30; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 32'(i), a);
      chk("basic_updates", 32'(upd_total - base), 32'd2);
      chk("basic_late",    {16'b0, late_cnt}, 32'd0);
      chk("basic_sig",     {24'b0, sig}, 32'h0000_00FD);

      // Fill past capacity, then play everything late across the wrap
      step(1'b0, '0, '0, 1'b0, 1'b1, 32'd0, a);
      for (int i = 0; i < DEPTH; i++) step(1'b1, 32'(100 + i), 8'(i * 7 + 1), 1'b0, 1'b0, 32'd0, a);
      step(1'b1, 32'd200, 8'sd77, 1'b0, 1'b0, 32'd0, a);
      step(1'b1, 32'd200, 8'sd77, 1'b0, 1'b0, 32'd0, a);
      chk("full_ready", {31'b0, in_ready}, 32'd0);
      base = upd_total;
      got  = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step(!got, 32'd200, 8'sd77, 1'b1, 1'b0, 32'd500, a);
         if (a) got = 1'b1;
      end
      chk("full_updates", 32'(upd_total - base), 32'd17);
      chk("full_burst",   32'(consec), 32'd17);
      chk("full_late",    {16'b0, late_cnt}, 32'd17);
      chk("full_sig",     {24'b0, sig}, 32'd77);

      // Ordering: decreasing timestamp rejected, equal accepted
      step(1'b0, '0, '0, 1'b1, 1'b1, 32'd0, a);
      chk("order_clear", {31'b0, order_err}, 32'd0);
      step(1'b1, 32'd30, 8'sd11, 1'b1, 1'b0, 32'd0, a);
      step(1'b1, 32'd25, 8'sd12, 1'b1, 1'b0, 32'd0, a);
      step(1'b1, 32'd30, 8'sd13, 1'b1, 1'b0, 32'd0, a);
      idle(1, 1'b1, 32'd0);
      chk("order_err_set", {31'b0, order_err}, 32'd1);
      base = upd_total;
      idle(5, 1'b1, 32'd100);
      chk("order_updates", 32'(upd_total - base), 32'd2);
      chk("order_sig",     {24'b0, sig}, 32'd13);

      // Same timestamp: consecutive pulses, last value wins
      for (int i = 1; i <= 3; i++) step(1'b1, 32'd40, 8'(i), 1'b1, 1'b0, 32'd0, a);
      idle(2, 1'b1, 32'd0);
      base = upd_total;
      idle(6, 1'b1, 32'd40);
      chk("same_updates", 32'(upd_total - base), 32'd3);
      chk("same_burst",   32'(consec), 32'd3);
      chk("same_sig",     {24'b0, sig}, 32'd3);

      // Flush with a simultaneous push while entries are pending
      for (int i = 0; i < 4; i++) step(1'b1, 32'(1000 + i), 8'(50 + i), 1'b1, 1'b0, 32'd0, a);
      step(1'b1, 32'd1001, 8'sd9, 1'b1, 1'b1, 32'd0, a);
      base = upd_total;
      idle(10, 1'b1, 32'd5000);
      chk("flush_updates", 32'(upd_total - base), 32'd0);
      chk("flush_sig",     {24'b0, sig}, 32'd3);

      // Unknown time must not fire
      step(1'b1, 32'd100, 8'sd21, 1'b1, 1'b0, 32'd0, a);
      idle(2, 1'b1, 32'd0);
      base = upd_total;
      for (int i = 0; i < 5; i++) begin
         step(1'b0, '0, '0, 1'b1, 1'b0, 32'd0, a);
         time_curr = 'x;
      end
      if ($isunknown(time_curr)) chk("xtime_updates", 32'(upd_total - base), 32'd0);
      idle(3, 1'b1, 32'd200);
      chk("xtime_sig", {24'b0, sig}, 32'd21);

      // Reset in the middle of playback
      for (int i = 0; i < 5; i++) step(1'b1, 32'(300 + 10 * i), 8'(60 + i), 1'b1, 1'b0, 32'd290, a);
      for (int i = 0; i < 15; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 32'(290 + i), a);
      @(negedge clk);
      rst_n = 1'b0;
      in_valid = 1'b0;
      sb_q.delete();
      m_last = '0;
      m_oerr = 1'b0;
      #1;
      chk("mrst_sig",       {{(32-SB){sig[SB-1]}}, sig}, 32'd0);
      chk("mrst_update",    {31'b0, update}, 32'd0);
      chk("mrst_late",      {16'b0, late_cnt}, 32'd0);
      chk("mrst_order_err", {31'b0, order_err}, 32'd0);
      chk("mrst_in_ready",  {31'b0, in_ready}, 32'd1);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      base = upd_total;
      idle(6, 1'b1, 32'd10000);
      chk("mrst_discard", 32'(upd_total - base), 32'd0);

      // Randomised traffic
      tc = '0;
      for (int i = 0; i < 2000; i++) begin
         tc = tc + 32'($urandom_range(0, 3));
         if ($urandom_range(0, 15) == 0) t = (tc > 20) ? tc - 32'($urandom_range(1, 20)) : '0;
         else t = tc + 32'($urandom_range(0, 30));
         step(1'($urandom_range(0, 1)), t, 8'($urandom), ($urandom_range(0, 9) != 0),
              ($urandom_range(0, 99) == 0), tc, a);
      end
      tc = tc + 32'd1000;
      for (int i = 0; i < 100 && sb_q.size() != 0; i++) idle(1, 1'b1, tc);
      idle(3, 1'b1, tc);
      chk("drain_empty", 32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
